// File: rtl/mem_bank_responder_pkg.sv
// Shared packet layout (the types.vh macro set: N, CORE_ID_BITS, PACKET_W, BACK_PKT_W, field MSB/LSB)
// plus localparams and FSM state type for the memory-bank responder.
`ifndef MEM_BANK_TYPES_VH
`define MEM_BANK_TYPES_VH
`define N             8
`define CORE_ID_BITS  3
`define FWD_DATA_LSB  0
`define FWD_DATA_MSB  31
`define FWD_ADDR_LSB  32
`define FWD_ADDR_MSB  39
`define FWD_OP_BIT    40
`define FWD_PRIO_LSB  41
`define FWD_PRIO_MSB  42
`define FWD_CORE_LSB  43
`define FWD_CORE_MSB  45
`define PACKET_W      46
`define BCK_DATA_LSB  0
`define BCK_DATA_MSB  31
`define BCK_OP_BIT    32
`define BCK_PRIO_LSB  33
`define BCK_PRIO_MSB  34
`define BCK_CORE_LSB  35
`define BCK_CORE_MSB  37
`define BACK_PKT_W    38
`endif

package mem_bank_responder_pkg;
    localparam int NCORES     = `N;
    localparam int CORE_W     = `CORE_ID_BITS;
    localparam int PKT_W      = `PACKET_W;
    localparam int BPKT_W     = `BACK_PKT_W;
    localparam int F_DATA_LSB = `FWD_DATA_LSB;
    localparam int F_ADDR_LSB = `FWD_ADDR_LSB;
    localparam int F_ADDR_MSB = `FWD_ADDR_MSB;
    localparam int F_OP_BIT   = `FWD_OP_BIT;
    localparam int F_PRIO_LSB = `FWD_PRIO_LSB;
    localparam int F_PRIO_MSB = `FWD_PRIO_MSB;
    localparam int F_CORE_LSB = `FWD_CORE_LSB;
    localparam int F_CORE_MSB = `FWD_CORE_MSB;
    localparam int B_DATA_LSB = `BCK_DATA_LSB;
    localparam int B_OP_BIT   = `BCK_OP_BIT;
    localparam int B_PRIO_LSB = `BCK_PRIO_LSB;
    localparam int B_PRIO_MSB = `BCK_PRIO_MSB;
    localparam int B_CORE_LSB = `BCK_CORE_LSB;
    localparam int B_CORE_MSB = `BCK_CORE_MSB;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;
endpackage

// File: rtl/mem_bank_responder_req_fifo.sv
// Request queue: DEPTH entries, pointers carry an extra wrap bit for occupancy.
// Full/empty are registered; a push on a full queue is accepted when a pop lands on the same edge.
module req_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wptr, r_rptr;
    logic [AW:0]      w_wptr_nxt, w_rptr_nxt, w_cnt_nxt;
    logic             r_full, r_empty;
    logic             w_do_push, w_do_pop;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign w_do_pop   = i_pop & ~r_empty;
    assign w_do_push  = i_push & (~r_full | w_do_pop);
    assign w_wptr_nxt = r_wptr + (AW+1)'(w_do_push);
    assign w_rptr_nxt = r_rptr + (AW+1)'(w_do_pop);
    assign w_cnt_nxt  = w_wptr_nxt - w_rptr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
        end
    end

    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    assign o_full  = r_full;
    assign o_empty = r_empty;
endmodule

// File: rtl/mem_bank_responder.sv
// Memory-bank endpoint: queues forward requests, runs them on a single-port bank, returns responses.
// BANK_WRITE_ACK_EN: when defined writes are acknowledged; otherwise only reads produce resp_valid.
module mem_bank_responder
    import mem_bank_responder_pkg::*;
#(
    parameter int N      = NCORES,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PKT_W-1:0]  req_pkt,
    input  logic              req_valid,
    output logic [BPKT_W-1:0] resp_pkt,
    output logic              resp_valid,
    output logic              queue_full,
    output logic [N-1:0]      dropped_core_vector,
    output logic [15:0]       drop_count
);
    logic              w_fifo_push, w_fifo_pop, w_fifo_full, w_fifo_empty, w_drop;
    logic [PKT_W-1:0]  w_head;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_wdata;
    logic              w_head_op, w_needs_resp;
    logic [N-1:0]      w_drop_onehot;
    logic [BPKT_W-1:0] w_resp_pkt;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_bank [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata, r_wdata;
    logic [CORE_W-1:0] r_core;
    logic [1:0]        r_prio;
    logic              r_op;
    logic [BPKT_W-1:0] r_resp_pkt;
    logic              r_resp_valid;
    logic [N-1:0]      r_drop_vec;
    logic [15:0]       r_drop_count;

    // The network cannot be stalled: a full queue without a same-edge pop drops the request.
    assign w_drop      = req_valid & w_fifo_full & ~w_fifo_pop;
    assign w_fifo_push = req_valid & (~w_fifo_full | w_fifo_pop);

    req_fifo #(.WIDTH(PKT_W), .DEPTH(QDEPTH)) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_fifo_push),
        .i_din   (req_pkt),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_head_addr   = w_head[F_ADDR_LSB +: ADDR_W];
    assign w_head_wdata  = w_head[F_DATA_LSB +: DATA_W];
    assign w_head_op     = w_head[F_OP_BIT];
    assign w_drop_onehot = {{(N-1){1'b0}}, 1'b1} << req_pkt[F_CORE_MSB:F_CORE_LSB];

`ifdef BANK_WRITE_ACK_EN
    assign w_needs_resp = 1'b1;
`else
    assign w_needs_resp = ~r_op;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_fifo_pop  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_needs_resp) begin
                    w_state_nxt = S_RESP;
                end else if (!w_fifo_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                if (!w_fifo_empty) begin
                    w_fifo_pop  = 1'b1;
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bank access is issued on the popping edge; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_fifo_pop) begin
            if (w_head_op) begin
                r_bank[w_head_addr] <= w_head_wdata;
            end else begin
                r_rdata <= r_bank[w_head_addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core  <= '0;
            r_prio  <= '0;
            r_op    <= 1'b0;
            r_wdata <= '0;
        end else if (w_fifo_pop) begin
            r_core  <= w_head[F_CORE_MSB:F_CORE_LSB];
            r_prio  <= w_head[F_PRIO_MSB:F_PRIO_LSB];
            r_op    <= w_head_op;
            r_wdata <= w_head_wdata;
        end
    end

    always_comb begin
        w_resp_pkt                          = '0;
        w_resp_pkt[B_CORE_MSB:B_CORE_LSB]   = r_core;
        w_resp_pkt[B_PRIO_MSB:B_PRIO_LSB]   = r_prio;
        w_resp_pkt[B_OP_BIT]                = r_op;
        w_resp_pkt[B_DATA_LSB +: DATA_W]    = r_op ? r_wdata : r_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_pkt   <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if ((r_state == S_ACCESS) && w_needs_resp) begin
                r_resp_valid <= 1'b1;
                r_resp_pkt   <= w_resp_pkt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_vec   <= '0;
            r_drop_count <= '0;
        end else begin
            r_drop_vec <= w_drop ? w_drop_onehot : '0;
            if (w_drop && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign resp_pkt            = r_resp_pkt;
    assign resp_valid          = r_resp_valid;
    assign queue_full          = w_fifo_full;
    assign dropped_core_vector = r_drop_vec;
    assign drop_count          = r_drop_count;
endmodule

// File: tb/tb_mem_bank_responder.sv
// Bench for mem_bank_responder: directed table, multi-cycle corner sequences, random traffic vs a queue model.
module tb_mem_bank_responder;
    import mem_bank_responder_pkg::*;

    localparam int QD = 4;
`ifdef BANK_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [PKT_W-1:0]  req_pkt;
    logic              req_valid;
    logic [BPKT_W-1:0] resp_pkt;
    logic              resp_valid, queue_full;
    logic [NCORES-1:0] dropped_core_vector;
    logic [15:0]       drop_count;

    always #5 clk = ~clk;

    mem_bank_responder #(.N(NCORES), .DATA_W(32), .ADDR_W(8), .QDEPTH(QD)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_pkt             (req_pkt),
        .req_valid           (req_valid),
        .resp_pkt            (resp_pkt),
        .resp_valid          (resp_valid),
        .queue_full          (queue_full),
        .dropped_core_vector (dropped_core_vector),
        .drop_count          (drop_count)
    );

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    // Reference model: request queue, a "server free from edge" time, scheduled responses, bank array.
    typedef struct { int due; logic [BPKT_W-1:0] pkt; } pend_t;
    logic [PKT_W-1:0]  mq[$];
    pend_t             pend[$];
    int                k = 0;
    int                free_edge = 0;
    logic [31:0]       mem [256];
    bit                written [256];
    int                m_dcnt = 0;
    logic [NCORES-1:0] m_dvec = '0;
    logic              m_rv = 1'b0;
    logic              m_full = 1'b0;
    logic [BPKT_W-1:0] m_pkt = '0;

    function automatic logic [PKT_W-1:0] rq(int core, int prio, int op, int addr, logic [31:0] d);
        return {3'(core), 2'(prio), 1'(op), 8'(addr), d};
    endfunction

    function automatic logic [BPKT_W-1:0] rs(int core, int prio, int op, logic [31:0] d);
        return {3'(core), 2'(prio), 1'(op), d};
    endfunction

    function automatic void model_edge(logic v, logic [PKT_W-1:0] p);
        int sz;
        bit pop;
        logic [PKT_W-1:0] h;
        logic [7:0] a;
        logic [31:0] d;
        sz   = mq.size();
        pop  = (sz > 0) && (k >= free_edge);
        m_rv = 1'b0;
        m_dvec = '0;
        if (pop) begin
            h = mq.pop_front();
            a = h[F_ADDR_MSB:F_ADDR_LSB];
            if (h[F_OP_BIT]) begin
                mem[a] = h[31:0];
                written[a] = 1'b1;
                d = h[31:0];
            end else begin
                d = mem[a];
            end
            if (!h[F_OP_BIT] || ACK) begin
                pend.push_back('{k + 1, rs(int'(h[F_CORE_MSB:F_CORE_LSB]), int'(h[F_PRIO_MSB:F_PRIO_LSB]),
                                         int'(h[F_OP_BIT]), d)});
                free_edge = k + 2;
            end else begin
                free_edge = k + 1;
            end
        end
        if (v) begin
            if (sz < QD || pop) begin
                mq.push_back(p);
            end else begin
                m_dvec = NCORES'(1) << p[F_CORE_MSB:F_CORE_LSB];
                if (m_dcnt < 65535) m_dcnt++;
            end
        end
        m_full = (mq.size() == QD);
        if (pend.size() > 0 && pend[0].due == k) begin
            m_rv  = 1'b1;
            m_pkt = pend[0].pkt;
            void'(pend.pop_front());
        end
        k++;
    endfunction

    function automatic void model_reset();
        mq.delete();
        pend.delete();
        free_edge = k;
        m_dcnt = 0;
        m_dvec = '0;
        m_rv = 1'b0;
        m_full = 1'b0;
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic step(input logic v, input logic [PKT_W-1:0] p);
        req_valid = v;
        req_pkt   = p;
        @(posedge clk);
        model_edge(v, p);
        @(negedge clk);
        vectors++;
        chk("resp_valid", 64'(resp_valid), 64'(m_rv));
        if (m_rv) chk("resp_pkt", 64'(resp_pkt), 64'(m_pkt));
        chk("queue_full", 64'(queue_full), 64'(m_full));
        chk("dropped_core_vector", 64'(dropped_core_vector), 64'(m_dvec));
        chk("drop_count", 64'(drop_count), 64'(m_dcnt));
        if (resp_valid === 1'b1) pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic chk_all_zero(string tag);
        vectors++;
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_pkt"}, 64'(resp_pkt), 64'd0);
        chk({tag, "_queue_full"}, 64'(queue_full), 64'd0);
        chk({tag, "_dropped"}, 64'(dropped_core_vector), 64'd0);
        chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    endtask

    typedef struct {
        logic              v;
        logic [PKT_W-1:0]  pkt;
        logic              rv;
        logic [BPKT_W-1:0] rpkt;
    } vec_t;
    vec_t tbl [6];

    initial begin
        logic [PKT_W-1:0] p;
        int core, addr, op, exp_pulses;

        tbl[0] = '{1'b1, rq(3, 2, 1, 8'h10, 32'hDEADBEEF), 1'b0, '0};
        tbl[1] = '{1'b1, rq(5, 1, 0, 8'h10, 32'h0), 1'b0, '0};
`ifdef BANK_WRITE_ACK_EN
        tbl[2] = '{1'b0, '0, 1'b1, rs(3, 2, 1, 32'hDEADBEEF)};
        tbl[3] = '{1'b0, '0, 1'b0, '0};
        tbl[4] = '{1'b0, '0, 1'b1, rs(5, 1, 0, 32'hDEADBEEF)};
`else
        tbl[2] = '{1'b0, '0, 1'b0, '0};
        tbl[3] = '{1'b0, '0, 1'b1, rs(5, 1, 0, 32'hDEADBEEF)};
        tbl[4] = '{1'b0, '0, 1'b0, '0};
`endif
        tbl[5] = '{1'b0, '0, 1'b0, '0};

        rst = 1'b1;
        req_valid = 1'b0;
        req_pkt = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        model_reset();

        // Write then read of the same address from another core.
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].pkt);
            vectors++;
            chk("tbl_resp_valid", 64'(resp_valid), 64'(tbl[i].rv));
            if (tbl[i].rv) chk("tbl_resp_pkt", 64'(resp_pkt), 64'(tbl[i].rpkt));
        end
        idle(4);

        // Single read on an idle block: response only in the cycle after edge t+2.
        step(1'b1, rq(2, 3, 0, 8'h10, 32'h0));
        chk("lat_t", 64'(resp_valid), 64'd0);
        step(1'b0, '0);
        chk("lat_t1", 64'(resp_valid), 64'd0);
        step(1'b0, '0);
        chk("lat_t2", 64'(resp_valid), 64'd1);
        chk("lat_data", 64'(resp_pkt), 64'(rs(2, 3, 0, 32'hDEADBEEF)));
        step(1'b0, '0);
        chk("lat_t3", 64'(resp_valid), 64'd0);
        idle(2);

        // Nine back-to-back reads: fills, push-with-pop at full, then exactly one drop.
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, rq((i + 1) % 8, i % 4, 0, 8'h10, 32'h0));
            if (i == 6) chk("burst_full6", 64'(queue_full), 64'd1);
            if (i == 7) begin
                chk("burst_full7", 64'(queue_full), 64'd1);
                chk("burst_nodrop7", 64'(dropped_core_vector), 64'd0);
            end
            if (i == 8) chk("burst_dropvec", 64'(dropped_core_vector), 64'h2);
        end
        idle(20);
        chk("burst_drop_count", 64'(drop_count), 64'd1);
        chk("burst_responses", 64'(pulses), 64'd8);

        // Interleaved write/read/write.
        pulses = 0;
        step(1'b1, rq(1, 0, 1, 8'h03, 32'h1234_5678));
        step(1'b1, rq(4, 2, 0, 8'h10, 32'h0));
        step(1'b1, rq(6, 1, 1, 8'h04, 32'hA5A5_0F0F));
        idle(10);
        exp_pulses = ACK ? 3 : 1;
        chk("wrw_responses", 64'(pulses), 64'(exp_pulses));

        // Reset while a read is in ACCESS with two requests still queued.
        for (int i = 0; i < 4; i++) step(1'b1, rq(i, 1, 0, 8'h10, 32'h0));
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midrst_hold");
        rst = 1'b0;
        idle(3);
        step(1'b1, rq(7, 2, 0, 8'h03, 32'h0));
        idle(4);

        // Random traffic, heavy enough to overflow the queue.
        for (int i = 0; i < 400; i++) begin
            core = $urandom_range(0, 7);
            addr = $urandom_range(0, 15);
            op   = written[addr] ? $urandom_range(0, 1) : 1;
            p    = rq(core, $urandom_range(0, 3), op, addr, $urandom);
            step($urandom_range(0, 9) < 7, p);
        end
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
